// File: rtl/turn_input_conditioner.sv
// Turn-switch input conditioner.
// Conditions the raw left, right and hazard switch levels into the clean,
// registered LI/RI request pair that the tail-light FSM consumes. Each raw
// input is synchronized by two flops and then debounced by a counter. A
// four-state Moore arbiter resolves the debounced levels into one legal
// request.
//
// Arbiter state encoding is {LI, RI}. The outputs are therefore the state
// flops themselves, with no decode logic between the register and the pins.

module turn_input_conditioner #(
  parameter int DB_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,      // synchronous, active-low
  input  logic left_sw,
  input  logic right_sw,
  input  logic haz_sw,
  output logic LI,
  output logic RI,
  output logic conflict,
  output logic chg
);

  // The debounce counter never passes DB_CYCLES-1, so this width always fits.
  localparam int CNT_W = (DB_CYCLES < 1) ? 1 : $clog2(DB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  // Channel order inside the per-input vectors.
  localparam int NCH   = 3;
  localparam int IDX_L = 0;
  localparam int IDX_R = 1;
  localparam int IDX_H = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RIGHT = 2'b01,
    ST_LEFT  = 2'b10,
    ST_HAZ   = 2'b11
  } state_e;

  logic [NCH-1:0]   raw;
  logic [NCH-1:0]   s1_q;
  logic [NCH-1:0]   s2_q;
  logic [NCH-1:0]   stable_q;
  logic [NCH-1:0]   stable_d;
  logic [CNT_W-1:0] cnt_q [NCH];
  logic [CNT_W-1:0] cnt_d [NCH];

  state_e state_q;
  state_e prev_state_q;
  logic   conflict_q;
  logic   chg_q;

  logic left_db;
  logic right_db;
  logic haz_db;

  assign raw = {haz_sw, right_sw, left_sw};

  // Debounce next state. The counter only advances while the synchronized
  // level disagrees with the stable level. Any agreement clears the counter,
  // so the stable level moves only after DB_CYCLES consecutive mismatches.
  always_comb begin
    // NOTE: every output gets a default before any branch. A path that leaves
    // a combinational signal unassigned would infer a latch.
    stable_d = stable_q;
    for (int i = 0; i < NCH; i++) begin
      cnt_d[i] = '0;
      if (s2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          stable_d[i] = s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Two-flop synchronizers and the debounce registers for all three inputs.
  always_ff @(posedge clk) begin
    // NOTE: state updates use non-blocking assignment. Every flop then sees
    // the pre-edge value of the others, which keeps s1 -> s2 a true
    // two-stage pipe.
    if (!reset) begin
      s1_q     <= '0;
      s2_q     <= '0;
      stable_q <= '0;
      // NOTE: the counter array is a handful of flops, not a RAM, so it is
      // cleared with the rest of the state. A reset mid-debounce then always
      // restarts the count.
      for (int i = 0; i < NCH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      s1_q     <= raw;
      s2_q     <= s1_q;
      stable_q <= stable_d;
      for (int i = 0; i < NCH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign left_db  = stable_q[IDX_L];
  assign right_db = stable_q[IDX_R];
  assign haz_db   = stable_q[IDX_H];

  // Arbiter FSM with a registered conflict flag. Hazard has top priority.
  // When left and right are both requested, a direction already held keeps
  // its hold (first come wins). Otherwise both are refused and a conflict
  // is flagged.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      conflict_q <= 1'b0;
    end else begin
      conflict_q <= 1'b0;
      if (haz_db) begin
        state_q <= ST_HAZ;
      end else if (left_db && right_db) begin
        if ((state_q != ST_LEFT) && (state_q != ST_RIGHT)) begin
          state_q    <= ST_IDLE;
          conflict_q <= 1'b1;
        end
      end else if (left_db) begin
        state_q <= ST_LEFT;
      end else if (right_db) begin
        state_q <= ST_RIGHT;
      end else begin
        state_q <= ST_IDLE;
      end
    end
  end

  // Change detector. chg pulses one edge after {LI, RI} takes a new value.
  // Both registers clear on reset, so leaving reset does not pulse chg.
  always_ff @(posedge clk) begin
    if (!reset) begin
      prev_state_q <= ST_IDLE;
      chg_q        <= 1'b0;
    end else begin
      prev_state_q <= state_q;
      chg_q        <= (state_q != prev_state_q);
    end
  end

  assign LI       = state_q[1];
  assign RI       = state_q[0];
  assign conflict = conflict_q;
  assign chg      = chg_q;

endmodule

// File: tb/tb_turn_input_conditioner.sv
// Directed bench for turn_input_conditioner (DB_CYCLES = 4).
// Stimulus steps push the expected {LI, RI, conflict, chg} for each future
// edge into a scoreboard queue. Every negative clock edge pops the entries
// that are due and compares them with the outputs.
// A raw change that the edge numbered k samples first reaches LI/RI after
// edge k+6. chg follows after edge k+7.

module tb_turn_input_conditioner;

  typedef struct {
    int         due;
    logic [3:0] exp;
    string      tag;
  } sb_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic left_sw = 1'b0;
  logic right_sw = 1'b0;
  logic haz_sw = 1'b0;
  logic LI;
  logic RI;
  logic conflict;
  logic chg;

  sb_t sb[$];
  int  cyc   = 0;
  int  total = 0;
  int  bad   = 0;

  turn_input_conditioner #(.DB_CYCLES(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .left_sw  (left_sw),
    .right_sw (right_sw),
    .haz_sw   (haz_sw),
    .LI       (LI),
    .RI       (RI),
    .conflict (conflict),
    .chg      (chg)
  );

  always #5 clk = ~clk;

  task automatic push(input int due, input logic [3:0] e, input string tag);
    sb_t item;
    item.due = due;
    item.exp = e;
    item.tag = tag;
    sb.push_back(item);
  endtask

  task automatic span(input int from, input int to, input logic [3:0] e,
                      input string tag);
    for (int c = from; c <= to; c++) push(c, e, tag);
  endtask

  // One rising edge. The outputs are then sampled on the falling edge, and
  // every scoreboard entry that has come due is checked.
  task automatic tick();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      sb_t item;
      item = sb.pop_front();
      total++;
      assert (({LI, RI, conflict, chg} === item.exp) && (item.due == cyc))
      else begin
        bad++;
        $error("FAIL %s edge=%0d due=%0d observed{LI,RI,conf,chg}=%b required=%b",
               item.tag, cyc, item.due, {LI, RI, conflict, chg}, item.exp);
      end
    end
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    logic [6:0] bounce_pat;

    // Reset is held for 2 edges with all switches high. Then reset is
    // released with the switches low.
    reset = 1'b0; left_sw = 1'b1; right_sw = 1'b1; haz_sw = 1'b1;
    span(1, 2, 4'b0000, "rst_hold");
    run(2);
    reset = 1'b1; left_sw = 1'b0; right_sw = 1'b0; haz_sw = 1'b0;
    k = cyc + 1;
    span(k, k + 9, 4'b0000, "rst_exit");
    run(10);

    // A clean left press.
    left_sw = 1'b1;
    k = cyc + 1;
    span(k, k + 5, 4'b0000, "left_wait");
    push(k + 6, 4'b1000, "left_on");
    push(k + 7, 4'b1001, "left_chg");
    push(k + 8, 4'b1000, "left_chg_end");
    run(9);
    // Right is added while left is held. The first press keeps its hold and
    // no conflict is flagged.
    right_sw = 1'b1;
    k = cyc + 1;
    span(k, k + 11, 4'b1000, "left_keeps");
    run(12);
    // Both switches are released on the same cycle. The design returns to
    // IDLE.
    left_sw = 1'b0; right_sw = 1'b0;
    k = cyc + 1;
    span(k, k + 5, 4'b1000, "both_off_wait");
    push(k + 6, 4'b0000, "both_off");
    push(k + 7, 4'b0001, "both_off_chg");
    push(k + 8, 4'b0000, "both_off_chg_end");
    run(9);

    // Bounce: left is high 3, low 1, high 2, then low. Every burst is shorter
    // than DB_CYCLES, so the outputs must not move.
    bounce_pat = 7'b1110110;
    k = cyc + 1;
    span(k, k + 15, 4'b0000, "bounce_quiet");
    for (int i = 6; i >= 0; i--) begin
      left_sw = bounce_pat[i];
      tick();
    end
    left_sw = 1'b0;
    run(9);
    // Left is then held for a solid 10-cycle run. LI rises on the 7th edge.
    left_sw = 1'b1;
    k = cyc + 1;
    span(k, k + 5, 4'b0000, "run_wait");
    push(k + 6, 4'b1000, "run_on");
    push(k + 7, 4'b1001, "run_chg");
    span(k + 8, k + 9, 4'b1000, "run_hold");
    run(10);
    left_sw = 1'b0;
    k = cyc + 1;
    span(k, k + 5, 4'b1000, "run_off_wait");
    push(k + 6, 4'b0000, "run_off");
    push(k + 7, 4'b0001, "run_off_chg");
    run(8);

    // Hazard priority over a held right request.
    right_sw = 1'b1;
    k = cyc + 1;
    span(k, k + 5, 4'b0000, "right_wait");
    push(k + 6, 4'b0100, "right_on");
    push(k + 7, 4'b0101, "right_chg");
    run(8);
    haz_sw = 1'b1;
    k = cyc + 1;
    span(k, k + 5, 4'b0100, "haz_wait");
    push(k + 6, 4'b1100, "haz_on");
    push(k + 7, 4'b1101, "haz_chg");
    push(k + 8, 4'b1100, "haz_hold");
    run(9);
    haz_sw = 1'b0;
    k = cyc + 1;
    span(k, k + 5, 4'b1100, "haz_off_wait");
    push(k + 6, 4'b0100, "back_to_right");
    push(k + 7, 4'b0101, "back_to_right_chg");
    run(8);
    right_sw = 1'b0;
    k = cyc + 1;
    span(k, k + 5, 4'b0100, "right_off_wait");
    push(k + 6, 4'b0000, "right_off");
    push(k + 7, 4'b0001, "right_off_chg");
    run(8);

    // Conflict: left and right rise together from IDLE.
    left_sw = 1'b1; right_sw = 1'b1;
    k = cyc + 1;
    span(k, k + 5, 4'b0000, "conf_wait");
    span(k + 6, k + 9, 4'b0010, "conf_set");
    run(10);
    right_sw = 1'b0;
    k = cyc + 1;
    span(k, k + 5, 4'b0010, "conf_hold");
    push(k + 6, 4'b1000, "conf_to_left");
    push(k + 7, 4'b1001, "conf_to_left_chg");
    run(8);
    left_sw = 1'b0;
    k = cyc + 1;
    span(k, k + 5, 4'b1000, "conf_left_off_wait");
    push(k + 6, 4'b0000, "conf_left_off");
    push(k + 7, 4'b0001, "conf_left_off_chg");
    run(8);

    // Reset arrives mid-debounce. The count restarts once reset is released.
    left_sw = 1'b1;
    k = cyc + 1;
    span(k, k + 3, 4'b0000, "mid_wait");
    run(4);
    reset = 1'b0;
    push(cyc + 1, 4'b0000, "mid_rst");
    tick();
    reset = 1'b1;
    k = cyc + 1;
    span(k, k + 5, 4'b0000, "post_rst_wait");
    push(k + 6, 4'b1000, "post_rst_on");
    push(k + 7, 4'b1001, "post_rst_chg");
    run(8);

    // Every scheduled expectation must have been consumed.
    total++;
    assert (sb.size() == 0)
    else begin
      bad++;
      $error("FAIL sb_drain observed=%0d entries left required=0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
